// File: rtl/condlogic_it_if.sv
// Execute-stage condition/predication bus for condlogic_it.
// Carries the optional exec/annul counters when COND_PERFCNT_EN is defined.
interface condlogic_it_if #(
    parameter int NCTX  = 2,
    parameter int ITMAX = 4,
    parameter int PCW   = 32
);
    localparam int CTXW = (NCTX > 1) ? $clog2(NCTX) : 1;
    localparam int LW   = $clog2(ITMAX + 1);

    logic             valid;
    logic             stall;
    logic             flush;
    logic [CTXW-1:0]  ctx;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             L;
    logic             Branch;
    logic             it_start;
    logic [3:0]       it_firstcond;
    logic [ITMAX-1:0] it_mask;
    logic [LW-1:0]    it_len;

    logic [3:0]       Flags;
    logic             CondEx;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             link;
    logic             BranchTakenE;
    logic             it_active;
    logic [LW-1:0]    it_left;
    logic             it_err;
`ifdef COND_PERFCNT_EN
    logic [PCW-1:0]   exec_cnt;
    logic [PCW-1:0]   annul_cnt;

    modport slave (
        input  valid, stall, flush, ctx, Cond, ALUFlags, FlagW,
               PCS, RegW, MemW, L, Branch,
               it_start, it_firstcond, it_mask, it_len,
        output Flags, CondEx, PCSrc, RegWrite, MemWrite, link, BranchTakenE,
               it_active, it_left, it_err, exec_cnt, annul_cnt
    );
    modport master (
        output valid, stall, flush, ctx, Cond, ALUFlags, FlagW,
               PCS, RegW, MemW, L, Branch,
               it_start, it_firstcond, it_mask, it_len,
        input  Flags, CondEx, PCSrc, RegWrite, MemWrite, link, BranchTakenE,
               it_active, it_left, it_err, exec_cnt, annul_cnt
    );
`else
    logic unused_pcw;
    assign unused_pcw = (PCW > 0);

    modport slave (
        input  valid, stall, flush, ctx, Cond, ALUFlags, FlagW,
               PCS, RegW, MemW, L, Branch,
               it_start, it_firstcond, it_mask, it_len,
        output Flags, CondEx, PCSrc, RegWrite, MemWrite, link, BranchTakenE,
               it_active, it_left, it_err
    );
    modport master (
        output valid, stall, flush, ctx, Cond, ALUFlags, FlagW,
               PCS, RegW, MemW, L, Branch,
               it_start, it_firstcond, it_mask, it_len,
        input  Flags, CondEx, PCSrc, RegWrite, MemWrite, link, BranchTakenE,
               it_active, it_left, it_err
    );
`endif
endinterface

// File: rtl/condlogic_it.sv
// Banked NZCV flags, condition evaluation, control gating and IT predication.
// Optional COND_PERFCNT_EN adds saturating executed/annulled counters.
module condlogic_it #(
    parameter int NCTX  = 2,
    parameter int ITMAX = 4,
    parameter int PCW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    condlogic_it_if.slave bus
);
    localparam int CTXW = (NCTX > 1) ? $clog2(NCTX) : 1;
    localparam int LW   = $clog2(ITMAX + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic [LW-1:0]    left_q, left_d;
    logic [3:0]       base_q, base_d;
    logic [ITMAX-1:0] mask_q, mask_d;
    logic             err_q, err_d;
    logic [3:0]       bank_q [NCTX];

    logic [CTXW-1:0]  sel;
    logic [3:0]       flags;
    logic [3:0]       cond_eff;
    logic [ITMAX-1:0] mask_sh;
    logic             cond_ex;
    logic             fire;
    logic             gate;
    logic             wr_en;
    logic             it_legal;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    return z;
            4'h1:    return ~z;
            4'h2:    return cf;
            4'h3:    return ~cf;
            4'h4:    return n;
            4'h5:    return ~n;
            4'h6:    return v;
            4'h7:    return ~v;
            4'h8:    return cf & ~z;
            4'h9:    return ~cf | z;
            4'hA:    return ~(n ^ v);
            4'hB:    return n ^ v;
            4'hC:    return ~z & ~(n ^ v);
            4'hD:    return z | (n ^ v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Out-of-range contexts alias bank 0 for both read and write.
    assign sel      = (32'(bus.ctx) < NCTX) ? bus.ctx : '0;
    assign flags    = bank_q[sel];
    assign mask_sh  = mask_q >> idx_q;
    assign cond_eff = (state_q == ACTIVE) ? {base_q[3:1], base_q[0] ^ mask_sh[0]} : bus.Cond;
    assign cond_ex  = cond_pass(cond_eff, flags);
    assign fire     = bus.valid & ~bus.stall & ~bus.flush;
    assign gate     = cond_ex & fire & ~bus.it_start;
    assign wr_en    = gate;
    assign it_legal = (bus.it_len != '0) && (32'(bus.it_len) <= ITMAX) &&
                      (bus.it_firstcond != 4'hF);

    assign bus.Flags        = flags;
    assign bus.CondEx       = cond_ex;
    assign bus.PCSrc        = bus.PCS & gate;
    assign bus.RegWrite     = bus.RegW & gate;
    assign bus.MemWrite     = bus.MemW & gate;
    assign bus.link         = bus.L & gate;
    assign bus.BranchTakenE = bus.Branch & gate;
    assign bus.it_active    = (state_q == ACTIVE);
    assign bus.it_left      = left_q;
    assign bus.it_err       = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCTX; i++) bank_q[i] <= '0;
        end else if (wr_en) begin
            if (bus.FlagW[1]) bank_q[sel][3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0]) bank_q[sel][1:0] <= bus.ALUFlags[1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        left_d  = left_q;
        base_d  = base_q;
        mask_d  = mask_q;
        err_d   = 1'b0;
        if (!bus.stall) begin
            if (state_q == ACTIVE && bus.flush) begin
                state_d = IDLE;
                idx_d   = '0;
                left_d  = '0;
            end else if (fire) begin
                if (state_q == IDLE) begin
                    if (bus.it_start) begin
                        if (it_legal) begin
                            state_d = ACTIVE;
                            base_d  = bus.it_firstcond;
                            mask_d  = bus.it_mask;
                            left_d  = bus.it_len;
                            idx_d   = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else begin
                    // A nested IT is reported but still occupies its slot.
                    err_d  = bus.it_start;
                    idx_d  = idx_q + 1'b1;
                    left_d = left_q - 1'b1;
                    if (left_q == LW'(1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            left_q  <= '0;
            base_q  <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            left_q  <= left_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

`ifdef COND_PERFCNT_EN
    logic [PCW-1:0] exec_q, annul_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_q  <= '0;
            annul_q <= '0;
        end else if (fire && !bus.it_start) begin
            if (cond_ex && exec_q != '1)   exec_q  <= exec_q + 1'b1;
            if (!cond_ex && annul_q != '1) annul_q <= annul_q + 1'b1;
        end
    end

    assign bus.exec_cnt  = exec_q;
    assign bus.annul_cnt = annul_q;
`else
    logic unused_pcw;
    assign unused_pcw = (PCW > 0);
`endif
endmodule

// File: tb/tb_condlogic_it.sv
// Directed bench for condlogic_it: queue-based reference model checked every
// cycle, plus literal expectations along the directed sequence.
module tb_condlogic_it;
    localparam int NCTX  = 2;
    localparam int ITMAX = 4;
    localparam int PCW   = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    condlogic_it_if #(.NCTX(NCTX), .ITMAX(ITMAX), .PCW(PCW)) bus ();
    condlogic_it #(.NCTX(NCTX), .ITMAX(ITMAX), .PCW(PCW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference state: flag banks, and the queue of conditions still owed to
    // the open IT block (its length is it_left, non-empty means active).
    logic [3:0] m_bank [NCTX] = '{default: 4'h0};
    logic [3:0] m_slots [$];
    logic       m_err = 1'b0;
`ifdef COND_PERFCNT_EN
    logic [PCW-1:0] m_exec = '0;
    logic [PCW-1:0] m_annul = '0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Conditions pair up: bits [3:1] choose the test, bit 0 inverts it.
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic r;
        case (c[3:1])
            3'd0:    r = f[2];
            3'd1:    r = f[1];
            3'd2:    r = f[3];
            3'd3:    r = f[0];
            3'd4:    r = f[1] & ~f[2];
            3'd5:    r = (f[3] == f[0]);
            3'd6:    r = ~f[2] & (f[3] == f[0]);
            default: r = 1'b0;
        endcase
        if (c[3:1] == 3'd7) return ~c[0];
        return r ^ c[0];
    endfunction

    function automatic int msel();
        return (int'(bus.ctx) < NCTX) ? int'(bus.ctx) : 0;
    endfunction

    function automatic logic [3:0] m_eff();
        return (m_slots.size() != 0) ? m_slots[0] : bus.Cond;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCTX; i++) m_bank[i] = 4'h0;
            m_slots.delete();
            m_err = 1'b0;
`ifdef COND_PERFCNT_EN
            m_exec  = '0;
            m_annul = '0;
`endif
        end else begin : upd
            logic [3:0] c;
            logic       p;
            int         s;
            s = msel();
            c = m_eff();
            p = ref_pass(c, m_bank[s]);
            m_err = 1'b0;
            if (!bus.stall) begin
                if (bus.flush) begin
                    m_slots.delete();
                end else if (bus.valid) begin
                    if (bus.it_start) begin
                        if (m_slots.size() != 0) begin
                            m_err = 1'b1;
                            void'(m_slots.pop_front());
                        end else if (int'(bus.it_len) >= 1 && int'(bus.it_len) <= ITMAX &&
                                     bus.it_firstcond != 4'hF) begin
                            for (int i = 0; i < int'(bus.it_len); i++)
                                m_slots.push_back({bus.it_firstcond[3:1],
                                                   bus.it_firstcond[0] ^ bus.it_mask[i]});
                        end else begin
                            m_err = 1'b1;
                        end
                    end else begin
                        if (p) begin
                            if (bus.FlagW[1]) m_bank[s][3:2] = bus.ALUFlags[3:2];
                            if (bus.FlagW[0]) m_bank[s][1:0] = bus.ALUFlags[1:0];
                        end
`ifdef COND_PERFCNT_EN
                        if (p && m_exec != '1)   m_exec++;
                        if (!p && m_annul != '1) m_annul++;
`endif
                        if (m_slots.size() != 0) void'(m_slots.pop_front());
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [3:0] f;
        logic       p, g;
        f = m_bank[msel()];
        p = ref_pass(m_eff(), f);
        g = p & bus.valid & ~bus.stall & ~bus.flush & ~bus.it_start;
        chk("Flags", bus.Flags, f);
        chk("CondEx", bus.CondEx, p);
        chk("PCSrc", bus.PCSrc, bus.PCS & g);
        chk("RegWrite", bus.RegWrite, bus.RegW & g);
        chk("MemWrite", bus.MemWrite, bus.MemW & g);
        chk("link", bus.link, bus.L & g);
        chk("BranchTakenE", bus.BranchTakenE, bus.Branch & g);
        chk("it_active", bus.it_active, m_slots.size() != 0);
        chk("it_left", bus.it_left, m_slots.size());
        chk("it_err", bus.it_err, m_err);
`ifdef COND_PERFCNT_EN
        chk("exec_cnt", bus.exec_cnt, m_exec);
        chk("annul_cnt", bus.annul_cnt, m_annul);
`endif
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.valid = 0; bus.stall = 0; bus.flush = 0; bus.ctx = '0;
        bus.Cond = 4'h0; bus.ALUFlags = 4'h0; bus.FlagW = 2'b00;
        bus.PCS = 0; bus.RegW = 0; bus.MemW = 0; bus.L = 0; bus.Branch = 0;
        bus.it_start = 0; bus.it_firstcond = 4'h0; bus.it_mask = '0; bus.it_len = '0;
        #12 reset = 1'b0;
        chk("rst_Flags", bus.Flags, 4'h0);
        chk("rst_active", bus.it_active, 1'b0);
        chk("rst_left", bus.it_left, 0);
        chk("rst_err", bus.it_err, 1'b0);

        // 1: EQ fails on clear flags, then set Z and pass
        next(); bus.valid = 1; bus.Cond = 4'h0; bus.RegW = 1; #1;
        chk("t1_condex", bus.CondEx, 1'b0);
        chk("t1_regwrite", bus.RegWrite, 1'b0);
        next(); bus.Cond = 4'hE; bus.ALUFlags = 4'b0100; bus.FlagW = 2'b11; #1;
        chk("t1_al_regwrite", bus.RegWrite, 1'b1);
        next(); bus.Cond = 4'h0; bus.FlagW = 2'b00; #1;
        chk("t1_flags", bus.Flags, 4'b0100);
        chk("t1_eq_regwrite", bus.RegWrite, 1'b1);

        // 2: bank 1 written with NZ only; MI per bank
        next(); bus.ctx = 1'b1; bus.Cond = 4'hE; bus.ALUFlags = 4'b1000; bus.FlagW = 2'b10;
        next(); bus.Cond = 4'h4; bus.FlagW = 2'b00; #1;
        chk("t2_bank1", bus.Flags, 4'b1000);
        chk("t2_mi_ctx1", bus.CondEx, 1'b1);
        bus.ctx = 1'b0; #1;
        chk("t2_bank0", bus.Flags, 4'b0100);
        chk("t2_mi_ctx0", bus.CondEx, 1'b0);

        // 3: IT EQ,NE,NE with own Cond=AL ignored
        next(); bus.it_start = 1; bus.it_firstcond = 4'h0; bus.it_mask = 4'b0110;
        bus.it_len = 3'd3; bus.Cond = 4'hE; #1;
        chk("t3_start_gated", bus.RegWrite, 1'b0);
        next(); bus.it_start = 0; #1;
        chk("t3_s0_active", bus.it_active, 1'b1);
        chk("t3_s0_left", bus.it_left, 3);
        chk("t3_s0_condex", bus.CondEx, 1'b1);
        next(); #1;
        chk("t3_s1_left", bus.it_left, 2);
        chk("t3_s1_condex", bus.CondEx, 1'b0);
        next(); #1;
        chk("t3_s2_left", bus.it_left, 1);
        chk("t3_s2_condex", bus.CondEx, 1'b0);
        next(); #1;
        chk("t3_done_active", bus.it_active, 1'b0);
        chk("t3_done_condex", bus.CondEx, 1'b1);

        // 4: stall holds the block, flush cancels it without a flag write
        next(); bus.it_start = 1; bus.it_mask = 4'b0000; bus.it_len = 3'd4;
        next(); bus.it_start = 0; #1;
        chk("t4_s0_left", bus.it_left, 4);
        next(); bus.stall = 1; bus.ALUFlags = 4'hF; bus.FlagW = 2'b11; #1;
        chk("t4_s1_left", bus.it_left, 3);
        next(); #1;
        chk("t4_stall1_left", bus.it_left, 3);
        next(); bus.stall = 0; bus.FlagW = 2'b00; #1;
        chk("t4_stall2_left", bus.it_left, 3);
        chk("t4_stall_flags", bus.Flags, 4'b0100);
        next(); bus.flush = 1; bus.FlagW = 2'b11; #1;
        chk("t4_s2_left", bus.it_left, 2);
        chk("t4_flush_gated", bus.RegWrite, 1'b0);
        next(); bus.flush = 0; bus.FlagW = 2'b00; bus.Cond = 4'h1; #1;
        chk("t4_flush_active", bus.it_active, 1'b0);
        chk("t4_flush_flags", bus.Flags, 4'b0100);
        chk("t4_direct_ne", bus.CondEx, 1'b0);

        // 5: illegal IT, nested IT, and NV condition
        next(); bus.it_start = 1; bus.it_len = 3'd0; bus.it_firstcond = 4'h0;
        next(); bus.it_start = 0; bus.Cond = 4'hE; #1;
        chk("t5_len0_err", bus.it_err, 1'b1);
        chk("t5_len0_idle", bus.it_active, 1'b0);
        next(); #1;
        chk("t5_err_pulse", bus.it_err, 1'b0);
        next(); bus.it_start = 1; bus.it_len = 3'd2; bus.it_firstcond = 4'hF;
        next(); bus.it_start = 0; #1;
        chk("t5_nv_err", bus.it_err, 1'b1);
        chk("t5_nv_idle", bus.it_active, 1'b0);
        next(); bus.it_start = 1; bus.it_firstcond = 4'hE; bus.it_mask = 4'b0000;
        next(); #1;
        chk("t5_nest_left0", bus.it_left, 2);
        chk("t5_nest_gated", bus.RegWrite, 1'b0);
        next(); bus.it_start = 0; #1;
        chk("t5_nest_err", bus.it_err, 1'b1);
        chk("t5_nest_left1", bus.it_left, 1);
        next(); #1;
        chk("t5_nest_done", bus.it_active, 1'b0);
        bus.Cond = 4'hF; bus.MemW = 1; bus.FlagW = 2'b11; bus.ALUFlags = 4'hF; #1;
        chk("t5_nv_condex", bus.CondEx, 1'b0);
        chk("t5_nv_memwrite", bus.MemWrite, 1'b0);
        next(); bus.FlagW = 2'b00; #1;
        chk("t5_nv_flags", bus.Flags, 4'b0100);

        // 6: asynchronous reset in the middle of an IT block
        bus.Cond = 4'hE; bus.ALUFlags = 4'hF; bus.FlagW = 2'b11; bus.MemW = 0;
        next(); bus.FlagW = 2'b00; bus.it_start = 1; bus.it_firstcond = 4'h0; bus.it_len = 3'd4; #1;
        chk("t6_flags_f", bus.Flags, 4'hF);
        next(); bus.it_start = 0;
        next(); #1;
        chk("t6_mid_left", bus.it_left, 3);
        reset = 1'b1; #1;
        chk("t6_async_active", bus.it_active, 1'b0);
        chk("t6_async_flags", bus.Flags, 4'h0);
        chk("t6_async_left", bus.it_left, 0);
`ifdef COND_PERFCNT_EN
        chk("t6_exec_zero", bus.exec_cnt, 0);
        chk("t6_annul_zero", bus.annul_cnt, 0);
`endif
        next(); reset = 1'b0;

        // Sweep all conditions over a set of flag values, both banks
        for (int k = 0; k < 10; k++) begin
            logic [39:0] fv;
            fv = 40'h0_4_8_1_2_9_6_F_A_5;
            bus.valid = 1; bus.ctx = 1'(k & 1); bus.Cond = 4'hE;
            bus.ALUFlags = fv[4*k +: 4]; bus.FlagW = 2'b11;
            next();
            bus.FlagW = 2'b00;
            for (int c = 0; c < 16; c++) begin
                bus.Cond = 4'(c);
                bus.ctx = 1'((c >> 2) & 1);
                {bus.PCS, bus.RegW, bus.MemW, bus.L, bus.Branch} = 5'(c * 7 + k);
                next();
            end
        end

        bus.valid = 0;
        next();
        next();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
